// File: rtl/led_burst_ctrl.sv
// led_burst_ctrl: programmable LED blink-burst sequencer.
// A descriptor (count, rate, repeat) is accepted over cfg_valid/cfg_ready while
// idle; the LED then toggles through on/off half-periods of 2^(BASE+rate) clk
// cycles, optionally looping with a GAP_TICKS half-period dark gap until abort.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_valid/cfg_ready descriptor handshake (cfg_ready is combinational)
//   cfg_count           blinks per burst, 0 means 16
//   cfg_rate            half-period exponent offset
//   cfg_repeat          loop bursts until abort
//   abort               return to idle on the next cycle
//   led, busy, done     registered LED drive, activity flag, end-of-burst pulse
//   blinks_left         blinks remaining including the current one (16 reads 0)
module led_burst_ctrl #(
  parameter int unsigned BASE      = 20,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_count,
  input  logic [2:0] cfg_rate,
  input  logic       cfg_repeat,
  input  logic       abort,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [3:0] blinks_left
);

  localparam int unsigned PW = BASE + 8;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_rate_q;
  logic          r_repeat_q;
  logic [4:0]    r_count_q;
  logic [4:0]    r_remaining;
  logic [3:0]    r_gap;
  logic          r_led;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_tick;
  logic [PW-1:0] w_limit;
  logic [4:0]    w_count;

  assign cfg_ready = (r_state == S_IDLE) && !abort;
  assign w_accept  = cfg_valid && cfg_ready;

  // Last prescaler value of a half-period at the latched rate.
  assign w_limit = (PW'(1) << (BASE + 32'(r_rate_q))) - PW'(1);
  assign w_tick  = (r_presc == w_limit);

  // A count of zero encodes a full 16-blink burst.
  assign w_count = (cfg_count == 4'd0) ? 5'd16 : {1'b0, cfg_count};

  // Sequencer state, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_rate_q    <= '0;
      r_repeat_q  <= 1'b0;
      r_count_q   <= '0;
      r_remaining <= '0;
      r_gap       <= '0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        r_state     <= S_IDLE;
        r_presc     <= '0;
        r_remaining <= '0;
        r_led       <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_rate_q    <= cfg_rate;
              r_repeat_q  <= cfg_repeat;
              r_count_q   <= w_count;
              r_remaining <= w_count;
              r_presc     <= '0;
              r_state     <= S_ON;
              r_led       <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_ON: begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              r_state <= S_OFF;
              r_led   <= 1'b0;
            end
          end
          S_OFF: begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              if (r_remaining > 5'd1) begin
                r_remaining <= r_remaining - 5'd1;
                r_state     <= S_ON;
                r_led       <= 1'b1;
              end else if (r_repeat_q) begin
                r_state <= S_GAP;
                r_gap   <= 4'(GAP_TICKS);
              end else begin
                r_state     <= S_IDLE;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
              end
            end
          end
          S_GAP: begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              r_gap <= r_gap - 4'd1;
              // Gap expires on the tick that brings the counter to zero.
              if (r_gap == 4'd1) begin
                r_remaining <= r_count_q;
                r_state     <= S_ON;
                r_led       <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign led         = r_led;
  assign busy        = r_busy;
  assign done        = r_done;
  assign blinks_left = r_remaining[3:0];

endmodule

// File: tb/tb_led_burst_ctrl.sv
module tb_led_burst_ctrl;

  localparam int unsigned BASE      = 2;
  localparam int unsigned GAP_TICKS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_count = '0;
  logic [2:0] cfg_rate = '0;
  logic       cfg_repeat = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_ready;
  logic       led;
  logic       busy;
  logic       done;
  logic [3:0] blinks_left;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic       done;
    logic [3:0] bl;
  } exp_t;

  exp_t q_exp[$];

  led_burst_ctrl #(.BASE(BASE), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_count(cfg_count), .cfg_rate(cfg_rate), .cfg_repeat(cfg_repeat),
    .abort(abort), .led(led), .busy(busy), .done(done),
    .blinks_left(blinks_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic l, input logic b, input logic d, input int bl);
    exp_t e;
    e.led  = l;
    e.busy = b;
    e.done = d;
    e.bl   = 4'(bl % 16);
    return e;
  endfunction

  // Expected per-cycle outputs from the cycle after accept, derived from the
  // burst rules: n blinks of half cycles on / half off, then done or a gap.
  function automatic void build(input int cnt, input int rate, input bit rep, input int limit);
    int half = 1 << (BASE + rate);
    int n = (cnt == 0) ? 16 : cnt;
    q_exp.delete();
    do begin
      for (int b = 0; b < n; b++) begin
        for (int k = 0; k < half; k++) q_exp.push_back(mk(1'b1, 1'b1, 1'b0, n - b));
        for (int k = 0; k < half; k++) q_exp.push_back(mk(1'b0, 1'b1, 1'b0, n - b));
      end
      if (!rep) q_exp.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      else for (int k = 0; k < int'(GAP_TICKS) * half; k++) q_exp.push_back(mk(1'b0, 1'b1, 1'b0, 1));
    end while (rep && q_exp.size() < limit);
    if (limit > 0) while (q_exp.size() > limit) void'(q_exp.pop_back());
  endfunction

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, ".led"},  8'(led),         8'(e.led));
    chk({tag, ".busy"}, 8'(busy),        8'(e.busy));
    chk({tag, ".done"}, 8'(done),        8'(e.done));
    chk({tag, ".bl"},   8'(blinks_left), 8'(e.bl));
  endtask

  // Offer a descriptor in the current (idle) cycle and follow the burst.
  // Returns in the cycle of the last checked entry without stepping past it.
  task automatic run_burst(input int cnt, input int rate, input bit rep,
                           input bit junk, input int limit, input string name);
    build(cnt, rate, rep, limit);
    cfg_valid  = 1'b1;
    cfg_count  = 4'(cnt);
    cfg_rate   = 3'(rate);
    cfg_repeat = rep;
    #1;
    chk({name, ".ready_accept"}, 8'(cfg_ready), 8'd1);
    step();
    for (int i = 0; i < q_exp.size(); i++) begin
      chk_outs($sformatf("%s.c%0d", name, i), q_exp[i]);
      if (junk && q_exp[i].busy) begin
        cfg_valid  = 1'b1;
        cfg_count  = 4'(~cnt);
        cfg_rate   = 3'($urandom_range(0, 7));
        cfg_repeat = ~rep;
      end else begin
        cfg_valid = 1'b0;
      end
      #1;
      chk($sformatf("%s.c%0d.ready", name, i), 8'(cfg_ready), 8'(!q_exp[i].busy));
      if (i < q_exp.size() - 1) step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_abort(input string name);
    cfg_valid = 1'b0;
    abort = 1'b1;
    step();
    chk_outs({name, ".abort"}, mk(1'b0, 1'b0, 1'b0, 0));
    abort = 1'b0;
    #1;
    chk({name, ".abort.ready"}, 8'(cfg_ready), 8'd1);
  endtask

  initial begin
    int cnt, rate, lim;
    bit rep, junk;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk_outs("reset", mk(1'b0, 1'b0, 1'b0, 0));
    chk("reset.ready", 8'(cfg_ready), 8'd1);
    rst_n = 1'b1;
    step();
    chk_outs("post_reset", mk(1'b0, 1'b0, 1'b0, 0));

    // Three blinks at the fastest rate, then chained bursts
    run_burst(3, 0, 1'b0, 1'b0, 0, "b3r0");
    run_burst(0, 1, 1'b0, 1'b1, 0, "b16r1_junk");
    run_burst(2, 0, 1'b1, 1'b1, 34, "rep2");
    do_abort("rep2");

    // abort outranks cfg_valid in idle
    cfg_valid = 1'b1; cfg_count = 4'd4; cfg_rate = 3'd0; cfg_repeat = 1'b0;
    abort = 1'b1;
    #1;
    chk("idle_abort.ready", 8'(cfg_ready), 8'd0);
    step();
    chk_outs("idle_abort", mk(1'b0, 1'b0, 1'b0, 0));
    abort = 1'b0; cfg_valid = 1'b0;
    step();
    chk_outs("idle_abort2", mk(1'b0, 1'b0, 1'b0, 0));

    // Reset in the middle of the first OFF phase of a 5-blink burst
    run_burst(5, 0, 1'b0, 1'b0, 6, "rst_mid");
    rst_n = 1'b0;
    step();
    chk_outs("rst_mid.reset", mk(1'b0, 1'b0, 1'b0, 0));
    rst_n = 1'b1;
    step();
    chk_outs("rst_mid.idle", mk(1'b0, 1'b0, 1'b0, 0));
    run_burst(1, 0, 1'b0, 1'b0, 0, "fresh1");

    // Randomised descriptors
    for (int it = 0; it < 8; it++) begin
      cnt  = int'($urandom_range(0, 15));
      rate = int'($urandom_range(0, 1));
      rep  = 1'($urandom_range(0, 1));
      junk = 1'($urandom_range(0, 1));
      lim  = rep ? int'($urandom_range(1, 300)) : 0;
      run_burst(cnt, rate, rep, junk, lim, $sformatf("rnd%0d", it));
      if (rep) do_abort($sformatf("rnd%0d", it));
      else if ($urandom_range(0, 1) == 1) begin
        step();
        chk_outs($sformatf("rnd%0d.idle", it), mk(1'b0, 1'b0, 1'b0, 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
